// File: rtl/fp_pkg.sv
// Shared types and constants for the FP register-file writeback path.
package fp_pkg;

  localparam int FP_NUM_REGS = 32;

  // fflags bit positions, matching the fcsr layout
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  flags;
  } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO of pending FPU results; the head is readable in the
// same cycle so the arbiter can pick it without an extra stage.
module fp_wb_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fp_wb_entry_t push_data_i,
  input  logic         pop_i,
  output fp_wb_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  fp_wb_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_reg == FULL_CNT);
  assign empty_o = (count_reg == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data_i;
  end

endmodule

// File: rtl/fp_writeback_ctrl.sv
// FP register-file write port: arbitrates LSU loads and buffered FPU results,
// tracks busy registers for issue stalls and accumulates sticky fflags.
module fp_writeback_ctrl
  import fp_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_REGS   = FP_NUM_REGS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  input  logic        issue_fregwrite_i,
  input  logic [4:0]  issue_frd_i,
  input  logic [4:0]  issue_freg1_i,
  input  logic [4:0]  issue_freg2_i,
  input  logic [4:0]  issue_freg3_i,
  input  logic [2:0]  issue_use_i,
  output logic        stall_o,
  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic [4:0]  fpu_rd_i,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_flags_i,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        fregwrite_o,
  output logic [4:0]  frd_o,
  output logic [31:0] writeback_data_o,
  input  logic        fflags_clr_i,
  output logic [4:0]  fflags_o
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;
  logic                src_busy;
  logic                waw_busy;
  logic                issue_accept;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fpu_xfer;
  fp_wb_entry_t        fifo_head;
  fp_wb_entry_t        fpu_entry;
  fp_wb_entry_t        win_entry;
  logic                win_valid;
  logic                win_is_fpu;

  logic                fregwrite_reg;
  logic [4:0]          frd_reg;
  logic [31:0]         wb_data_reg;
  logic [4:0]          fflags_reg;
  logic [4:0]          fflags_next;

  // Hazard check against registered busy bits only; no forwarding.
  assign src_busy = (issue_use_i[0] && busy_reg[issue_freg1_i]) ||
                    (issue_use_i[1] && busy_reg[issue_freg2_i]) ||
                    (issue_use_i[2] && busy_reg[issue_freg3_i]);
  assign waw_busy     = issue_fregwrite_i && busy_reg[issue_frd_i];
  assign stall_o      = issue_valid_i && (src_busy || waw_busy);
  assign issue_accept = issue_valid_i && !stall_o;

  assign fpu_ready_o = !fifo_full;
  assign fpu_xfer    = fpu_valid_i && fpu_ready_o;
  assign fpu_entry   = '{rd: fpu_rd_i, data: fpu_result_i, flags: fpu_flags_i};

  fp_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (fpu_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // LSU cannot be stalled, so it always wins; the FIFO head keeps FPU order.
  always_comb begin
    win_valid  = 1'b0;
    win_is_fpu = 1'b0;
    win_entry  = '0;
    fifo_pop   = 1'b0;
    fifo_push  = fpu_xfer;
    if (lsu_valid_i) begin
      win_valid = 1'b1;
      win_entry = '{rd: lsu_rd_i, data: lsu_data_i, flags: 5'b0};
    end else if (!fifo_empty) begin
      win_valid  = 1'b1;
      win_is_fpu = 1'b1;
      win_entry  = fifo_head;
      fifo_pop   = 1'b1;
    end else if (fpu_xfer) begin
      win_valid  = 1'b1;
      win_is_fpu = 1'b1;
      win_entry  = fpu_entry;
      fifo_push  = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    assign busy_set[gi]  = issue_accept && issue_fregwrite_i && (issue_frd_i == 5'(gi));
    assign busy_clr[gi]  = win_valid && (win_entry.rd == 5'(gi));
    assign busy_next[gi] = busy_set[gi] || (busy_reg[gi] && !busy_clr[gi]);
  end

  assign fflags_next = (fflags_clr_i ? 5'b0 : fflags_reg) |
                       (win_is_fpu ? win_entry.flags : 5'b0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_reg      <= '0;
      fregwrite_reg <= 1'b0;
      frd_reg       <= '0;
      wb_data_reg   <= '0;
      fflags_reg    <= '0;
    end else begin
      busy_reg      <= busy_next;
      fregwrite_reg <= win_valid;
      fflags_reg    <= fflags_next;
      if (win_valid) begin
        frd_reg     <= win_entry.rd;
        wb_data_reg <= win_entry.data;
      end
    end
  end

  assign fregwrite_o      = fregwrite_reg;
  assign frd_o            = frd_reg;
  assign writeback_data_o = wb_data_reg;
  assign fflags_o         = fflags_reg;

endmodule

// File: tb/tb_fp_writeback_ctrl.sv
// Directed bench for fp_writeback_ctrl with a queue-based reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_fp_writeback_ctrl;
  import fp_pkg::*;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i, issue_fregwrite_i;
  logic [4:0]  issue_frd_i, issue_freg1_i, issue_freg2_i, issue_freg3_i;
  logic [2:0]  issue_use_i;
  logic        stall_o;
  logic        fpu_valid_i, fpu_ready_o;
  logic [4:0]  fpu_rd_i, fpu_flags_i;
  logic [31:0] fpu_result_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        fregwrite_o;
  logic [4:0]  frd_o;
  logic [31:0] writeback_data_o;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;

  always #5 clk_i = ~clk_i;

  fp_writeback_ctrl #(.FIFO_DEPTH(DEPTH), .NUM_REGS(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_fregwrite_i(issue_fregwrite_i),
    .issue_frd_i(issue_frd_i), .issue_freg1_i(issue_freg1_i),
    .issue_freg2_i(issue_freg2_i), .issue_freg3_i(issue_freg3_i),
    .issue_use_i(issue_use_i), .stall_o(stall_o),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_rd_i(fpu_rd_i),
    .fpu_result_i(fpu_result_i), .fpu_flags_i(fpu_flags_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .fregwrite_o(fregwrite_o), .frd_o(frd_o), .writeback_data_o(writeback_data_o),
    .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  bit           model_busy [32];
  fp_wb_entry_t model_q [$];
  logic         exp_we = 1'b0;
  logic [4:0]   exp_rd = '0;
  logic [31:0]  exp_data = '0;
  logic [4:0]   exp_flags = '0;

  logic [4:0]   wr_log [$];
  logic [4:0]   bp_exp [8] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd22, 5'd23};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    logic s;
    s = (issue_use_i[0] && model_busy[issue_freg1_i]) ||
        (issue_use_i[1] && model_busy[issue_freg2_i]) ||
        (issue_use_i[2] && model_busy[issue_freg3_i]) ||
        (issue_fregwrite_i && model_busy[issue_frd_i]);
    return issue_valid_i && s;
  endfunction

  // Model: FPU results join an in-order queue; each cycle the LSU takes the
  // port if present, otherwise the oldest FPU result (possibly just arrived).
  initial begin
    fp_wb_entry_t w, incoming;
    bit have, w_fpu, xfer, accept;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        foreach (model_busy[i]) model_busy[i] = 1'b0;
        model_q.delete();
        exp_we = 1'b0; exp_rd = '0; exp_data = '0; exp_flags = '0;
      end else begin
        accept   = issue_valid_i && !model_stall();
        xfer     = fpu_valid_i && (model_q.size() < DEPTH);
        incoming = '{rd: fpu_rd_i, data: fpu_result_i, flags: fpu_flags_i};
        have = 1'b0; w_fpu = 1'b0; w = '0;
        if (xfer) model_q.push_back(incoming);
        if (lsu_valid_i) begin
          have = 1'b1;
          w = '{rd: lsu_rd_i, data: lsu_data_i, flags: 5'b0};
        end else if (model_q.size() > 0) begin
          have = 1'b1; w_fpu = 1'b1;
          w = model_q.pop_front();
        end
        if (have && accept && issue_fregwrite_i && (issue_frd_i == w.rd)) begin
          errors++;
          $display("FAIL busy_set_clr_same_edge: rd %0d at %0t", w.rd, $time);
        end
        if (have) model_busy[w.rd] = 1'b0;
        if (accept && issue_fregwrite_i) model_busy[issue_frd_i] = 1'b1;
        exp_flags = (fflags_clr_i ? 5'b0 : exp_flags) | (w_fpu ? w.flags : 5'b0);
        exp_we = have;
        if (have) begin
          exp_rd = w.rd;
          exp_data = w.data;
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (cmp_en) begin
        chk("m_fregwrite", fregwrite_o, exp_we);
        if (exp_we || !rst_ni) begin
          chk("m_frd", frd_o, exp_rd);
          chk("m_wb_data", writeback_data_o, exp_data);
        end
        chk("m_fflags", fflags_o, exp_flags);
        chk("m_ready", fpu_ready_o, model_q.size() < DEPTH);
        chk("m_stall", stall_o, model_stall());
        if (fregwrite_o) wr_log.push_back(frd_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_fregwrite_i = 0; issue_frd_i = 0;
    issue_freg1_i = 0; issue_freg2_i = 0; issue_freg3_i = 0; issue_use_i = 0;
    fpu_valid_i = 0; fpu_rd_i = 0; fpu_result_i = 0; fpu_flags_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0; fflags_clr_i = 0;
  endtask

  task automatic issue(input logic fw, input logic [4:0] rd, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] c, input logic [2:0] use_m);
    issue_valid_i = 1; issue_fregwrite_i = fw; issue_frd_i = rd;
    issue_freg1_i = a; issue_freg2_i = b; issue_freg3_i = c; issue_use_i = use_m;
  endtask

  task automatic fpu(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] fl);
    fpu_valid_i = 1; fpu_rd_i = rd; fpu_result_i = d; fpu_flags_i = fl;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid_i = 1; lsu_rd_i = rd; lsu_data_i = d;
  endtask

  initial begin
    int k, cyc;
    logic rdy;
    idle();
    // Reset state
    repeat (3) tick();
    cmp_en = 1'b1;
    @(negedge clk_i);
    chk("rst_fregwrite", fregwrite_o, 0);
    chk("rst_frd", frd_o, 0);
    chk("rst_data", writeback_data_o, 0);
    chk("rst_fflags", fflags_o, 0);
    chk("rst_stall", stall_o, 0);
    tick(); rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", fpu_ready_o, 1);

    // Bypass latency with f3 marked busy beforehand
    tick(); idle(); issue(1, 5'd3, 0, 0, 0, 3'b000);
    tick(); idle(); fpu(5'd3, 32'h4040_0000, 5'(1 << FFLAG_NX)); issue(0, 0, 5'd3, 0, 0, 3'b001);
    @(negedge clk_i);
    chk("byp_raw_stall", stall_o, 1);
    tick(); idle(); issue(0, 0, 5'd3, 0, 0, 3'b001);
    @(negedge clk_i);
    chk("byp_fregwrite", fregwrite_o, 1);
    chk("byp_frd", frd_o, 3);
    chk("byp_data", writeback_data_o, 32'h4040_0000);
    chk("byp_fflags", fflags_o, 5'b00001);
    chk("byp_busy_clear", stall_o, 0);

    // RAW/WAW on f4
    tick(); idle(); issue(1, 5'd4, 0, 0, 0, 3'b000);
    tick(); idle(); issue(0, 0, 0, 5'd4, 0, 3'b010);
    @(negedge clk_i); chk("raw_f4_stall", stall_o, 1);
    tick(); idle(); issue(1, 5'd4, 0, 0, 0, 3'b000);
    @(negedge clk_i); chk("waw_f4_stall", stall_o, 1);
    tick(); idle(); issue(0, 0, 0, 0, 5'd4, 3'b100); fpu(5'd4, 32'h4080_0000, 5'b0);
    @(negedge clk_i); chk("raw_f4_win_cycle", stall_o, 1);
    tick(); idle(); issue(0, 0, 0, 0, 5'd4, 3'b100);
    @(negedge clk_i);
    chk("raw_f4_release", stall_o, 0);
    chk("f4_written", frd_o, 4);
    tick(); idle(); issue(1, 5'd4, 0, 0, 0, 3'b000);
    @(negedge clk_i); chk("waw_f4_release", stall_o, 0);
    tick(); idle(); lsu(5'd4, 32'h0000_0004);

    // LSU / FPU collision
    tick(); idle(); lsu(5'd7, 32'h3F80_0000); fpu(5'd8, 32'h4000_0000, 5'(1 << FFLAG_UF));
    tick(); idle();
    @(negedge clk_i);
    chk("col_frd_lsu", frd_o, 7);
    chk("col_data_lsu", writeback_data_o, 32'h3F80_0000);
    tick();
    @(negedge clk_i);
    chk("col_frd_fpu", frd_o, 8);
    chk("col_data_fpu", writeback_data_o, 32'h4000_0000);
    chk("col_fflags", fflags_o, 5'b00011);
    tick();
    @(negedge clk_i);
    chk("col_idle", fregwrite_o, 0);

    // fflags clear
    tick(); idle(); fflags_clr_i = 1;
    tick(); idle(); fpu(5'd9, 32'h1, 5'(1 << FFLAG_NV));
    tick(); idle();
    @(negedge clk_i); chk("ff_nv", fflags_o, 5'b10000);
    tick(); idle(); fflags_clr_i = 1; fpu(5'd9, 32'h2, 5'(1 << FFLAG_OF));
    tick(); idle();
    @(negedge clk_i); chk("ff_clr_new", fflags_o, 5'b00100);
    tick(); idle();
    @(negedge clk_i); wr_log.delete();

    // Backpressure: 4-cycle LSU burst against a continuously valid FPU
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      tick(); idle();
      if (cyc < 4) lsu(5'(10 + cyc), 32'h3000_0000 + 32'(cyc));
      fpu(5'(20 + k), 32'h4100_0000 + 32'(k), 5'b0);
      @(negedge clk_i);
      rdy = fpu_ready_o;
      if (cyc == 2) chk("bp_ready_drop", fpu_ready_o, 0);
      if (rdy) k++;
      cyc++;
    end
    chk("bp_accepted", k, 4);
    tick(); idle();
    repeat (5) tick();
    chk("bp_write_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wr_log.size()) chk("bp_order", wr_log[i], bp_exp[i]);

    // Reset mid-stream: f5 busy, two FPU results queued
    tick(); idle(); issue(1, 5'd5, 0, 0, 0, 3'b000);
    tick(); idle(); lsu(5'd14, 32'hE); fpu(5'd21, 32'h21, 5'b0);
    tick(); idle(); lsu(5'd15, 32'hF); fpu(5'd22, 32'h22, 5'b0);
    tick(); idle(); rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst2_fregwrite", fregwrite_o, 0);
    chk("rst2_frd", frd_o, 0);
    chk("rst2_data", writeback_data_o, 0);
    chk("rst2_fflags", fflags_o, 0);
    tick(); tick(); rst_ni = 1'b1; issue(0, 0, 5'd5, 0, 0, 3'b001);
    @(negedge clk_i);
    chk("rst2_ready", fpu_ready_o, 1);
    chk("rst2_f5_nostall", stall_o, 0);
    tick(); idle();
    repeat (4) tick();
    @(negedge clk_i);
    chk("rst2_no_stale_write", fregwrite_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
